// File: rtl/perf_stat_pkg.sv
// ---------------------------------------------------------------------------
// perf_stat_pkg
// Shared constants for the performance-counter display path: the counter
// select codes, special segment patterns and display geometry.
// No ports (package).
// ---------------------------------------------------------------------------
package perf_stat_pkg;

  // Number of hex digits on the multiplexed display
  localparam int DIGITS  = 8;

  // Number of statistics counters that can be selected
  localparam int NUM_CNT = 5;

  // Counter select codes; anything above SEL_LU is invalid
  localparam logic [2:0] SEL_TOTAL   = 3'd0;
  localparam logic [2:0] SEL_COND    = 3'd1;
  localparam logic [2:0] SEL_UNCOND  = 3'd2;
  localparam logic [2:0] SEL_COND_OK = 3'd3;
  localparam logic [2:0] SEL_LU      = 3'd4;

  // Active-low segment patterns {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

endpackage

// File: rtl/seg7_hex_decode.sv
// ---------------------------------------------------------------------------
// seg7_hex_decode
// Purely combinational hex nibble to 7-segment decoder, active-low outputs.
// Lower-case glyphs are used for b and d so they differ from 8 and 0.
//   nibble_i : 4-bit value to show (0..F)
//   seg_o    : segments {g,f,e,d,c,b,a}, 0 = segment lit
// ---------------------------------------------------------------------------
module seg7_hex_decode (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Straight lookup of the sixteen hex glyphs
  always_comb begin
    seg_o = 7'h7F;
    case (nibble_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/perf_stat_display.sv
// ---------------------------------------------------------------------------
// perf_stat_display
// Shows one of the five CPU performance counters as 8 hex digits on the
// board's multiplexed 7-segment display. All counters are frozen together
// when the halt lock rises so the values read off the board are coherent,
// and the shown counter can either be picked manually or auto-rotated.
//   clk, rst            : system clock, synchronous active-high reset
//   lock                : halt lock from the counter block (1 = halted)
//   total .. lu_times   : live 32-bit statistics counters
//   sel                 : manual counter select (5..7 show dashes)
//   auto_rot            : 1 = rotate through counters, ignoring sel
//   an                  : digit enables, active-low, bit 0 = least significant
//   seg                 : segments {dp,g,f,e,d,c,b,a}, active-low
//   cur_sel             : counter index currently displayed
// ---------------------------------------------------------------------------
module perf_stat_display
  import perf_stat_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int ROT_FRAMES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lock,
  input  logic [31:0] total,
  input  logic [31:0] conditional,
  input  logic [31:0] unconditional,
  input  logic [31:0] conditional_success,
  input  logic [31:0] lu_times,
  input  logic [2:0]  sel,
  input  logic        auto_rot,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic [2:0]  cur_sel
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRM_W = (ROT_FRAMES > 1) ? $clog2(ROT_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(ROT_FRAMES - 1);
  localparam logic [2:0]       DIGIT_LAST = 3'(DIGITS - 1);

  logic [31:0]      live   [NUM_CNT];
  logic [31:0]      snap_q [NUM_CNT];
  logic             lock_q;
  logic             autoRot_q;
  logic [DIV_W-1:0] divCnt_q,   divCnt_d;
  logic [2:0]       digitIdx_q, digitIdx_d;
  logic [FRM_W-1:0] frameCnt_q, frameCnt_d;
  logic [2:0]       rot_q,      rot_d;
  logic [2:0]       curSel_q,   curSel_d;
  logic [7:0]       an_q,       an_d;
  logic [7:0]       seg_q,      seg_d;
  logic             divWrap, digitWrap, frameWrap;
  logic [31:0]      selVal;
  logic             selValid;
  logic [3:0]       nibble;
  logic [6:0]       hexSeg;

  assign live[SEL_TOTAL]   = total;
  assign live[SEL_COND]    = conditional;
  assign live[SEL_UNCOND]  = unconditional;
  assign live[SEL_COND_OK] = conditional_success;
  assign live[SEL_LU]      = lu_times;

  // Snapshot registers track the live counters every cycle, except that once
  // lock has been high for more than one cycle they hold. The rising-edge
  // cycle itself still loads, which captures the value present when the
  // program halted.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= 1'b0;
      for (int i = 0; i < NUM_CNT; i++) snap_q[i] <= '0;
    end else begin
      lock_q <= lock;
      if (!(lock && lock_q)) begin
        for (int i = 0; i < NUM_CNT; i++) snap_q[i] <= live[i];
      end
    end
  end

  // Scan timing: a clock divider picks the digit slot, eight slots make a
  // frame, and the frame counter paces the auto-rotate.
  always_comb begin
    divWrap    = (divCnt_q == DIV_LAST);
    digitWrap  = divWrap && (digitIdx_q == DIGIT_LAST);
    frameWrap  = digitWrap && (frameCnt_q == FRM_LAST);
    divCnt_d   = divWrap ? '0 : divCnt_q + DIV_W'(1);
    digitIdx_d = divWrap ? digitIdx_q + 3'd1 : digitIdx_q;
    frameCnt_d = frameCnt_q;
    if (digitWrap) frameCnt_d = frameWrap ? '0 : frameCnt_q + FRM_W'(1);
  end

  // Rotate index restarts at the first counter when auto-rotate is switched
  // on and otherwise steps once per rotate period; it simply holds while
  // auto-rotate is off. cur_sel follows the next rotate value so the restart
  // is visible on the same edge as the switch-on.
  always_comb begin
    rot_d = rot_q;
    if (auto_rot && !autoRot_q) begin
      rot_d = SEL_TOTAL;
    end else if (auto_rot && frameWrap) begin
      rot_d = (rot_q == SEL_LU) ? SEL_TOTAL : rot_q + 3'd1;
    end
    curSel_d = auto_rot ? rot_d : sel;
  end

  // Pick the frozen counter being shown and the nibble for the active digit.
  // Out-of-range selects are flagged so every digit shows a dash.
  always_comb begin
    selVal   = snap_q[SEL_TOTAL];
    selValid = 1'b1;
    case (curSel_q)
      SEL_TOTAL:   selVal = snap_q[SEL_TOTAL];
      SEL_COND:    selVal = snap_q[SEL_COND];
      SEL_UNCOND:  selVal = snap_q[SEL_UNCOND];
      SEL_COND_OK: selVal = snap_q[SEL_COND_OK];
      SEL_LU:      selVal = snap_q[SEL_LU];
      default:     selValid = 1'b0;
    endcase
    nibble = selVal[{digitIdx_q, 2'b00} +: 4];
  end

  seg7_hex_decode u_decode (
    .nibble_i (nibble),
    .seg_o    (hexSeg)
  );

  // Next pin values. The decimal point on the least significant digit acts
  // as the halt indicator.
  always_comb begin
    an_d  = ~(8'b1 << digitIdx_q);
    seg_d = selValid ? {1'b1, hexSeg} : SEG_DASH;
    if (lock && (digitIdx_q == 3'd0)) seg_d[7] = 1'b0;
  end

  // All counters and the pin registers, so the board sees glitch-free
  // digit enables and segments.
  always_ff @(posedge clk) begin
    if (rst) begin
      divCnt_q   <= '0;
      digitIdx_q <= 3'd0;
      frameCnt_q <= '0;
      rot_q      <= SEL_TOTAL;
      autoRot_q  <= 1'b0;
      curSel_q   <= SEL_TOTAL;
      an_q       <= 8'hFF;
      seg_q      <= SEG_BLANK;
    end else begin
      divCnt_q   <= divCnt_d;
      digitIdx_q <= digitIdx_d;
      frameCnt_q <= frameCnt_d;
      rot_q      <= rot_d;
      autoRot_q  <= auto_rot;
      curSel_q   <= curSel_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign an      = an_q;
  assign seg     = seg_q;
  assign cur_sel = curSel_q;

endmodule

// File: tb/tb_perf_stat_display.sv
module tb_perf_stat_display;

  localparam int SCAN_DIV   = 4;
  localparam int ROT_FRAMES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lock = 1'b0;
  logic        autoRot = 1'b0;
  logic [31:0] total = '0;
  logic [31:0] conditional = '0;
  logic [31:0] unconditional = '0;
  logic [31:0] conditionalSuccess = '0;
  logic [31:0] luTimes = '0;
  logic [2:0]  sel = '0;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic [2:0]  curSel;

  int checks = 0;
  int errors = 0;

  // Expected segment pattern for each digit of the next frame, in scan order
  logic [7:0] expSeg[$];

  logic countEn = 1'b0;
  logic lockAtHit = 1'b0;

  perf_stat_display #(.SCAN_DIV(SCAN_DIV), .ROT_FRAMES(ROT_FRAMES)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .lock                (lock),
    .total               (total),
    .conditional         (conditional),
    .unconditional       (unconditional),
    .conditional_success (conditionalSuccess),
    .lu_times            (luTimes),
    .sel                 (sel),
    .auto_rot            (autoRot),
    .an                  (an),
    .seg                 (seg),
    .cur_sel             (curSel)
  );

  always #5 clk = ~clk;

  // Free-running total counter; raises lock on the cycle it reaches 0x100
  always @(negedge clk) begin
    if (countEn) begin
      total = total + 32'd1;
      if (lockAtHit && total == 32'h0000_0100) lock = 1'b1;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Reference active-low hex glyphs {dp,g..a}, dp off
  function automatic logic [7:0] hexSeg(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] t, input logic [31:0] c, input logic [31:0] u,
                               input logic [31:0] cs, input logic [31:0] lu, input logic [2:0] s);
    total = t;
    conditional = c;
    unconditional = u;
    conditionalSuccess = cs;
    luTimes = lu;
    sel = s;
  endtask

  // Push the eight expected digits of a 32-bit value (dp on digit 0 if asked)
  task automatic pushValue(input logic [31:0] v, input bit dp0);
    logic [7:0] s;
    for (int k = 0; k < 8; k++) begin
      s = hexSeg(v[4*k +: 4]);
      if (dp0 && k == 0) s[7] = 1'b0;
      expSeg.push_back(s);
    end
  endtask

  // Wait for the next frame start and check every cycle of every digit slot
  task automatic checkFrame(input string tag);
    logic [7:0] prevAn;
    logic [7:0] wantAn;
    logic [7:0] want;
    bit found;
    prevAn = an;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (an == 8'hFE && prevAn != 8'hFE) found = 1'b1;
      else prevAn = an;
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("[TB] FAIL %s_start observed=no-frame expected=an FE", tag);
    end
    if (found) begin
      for (int k = 0; k < 8; k++) begin
        want = expSeg.pop_front();
        wantAn = 8'h01 << k;
        wantAn = ~wantAn;
        for (int c = 0; c < SCAN_DIV; c++) begin
          if (!(k == 0 && c == 0)) @(negedge clk);
          checkOutput({tag, "_an"}, an, wantAn);
          checkOutput({tag, "_seg"}, seg, want);
        end
      end
    end
    expSeg.delete();
  endtask

  initial begin
    logic [7:0] prevAn;
    logic [7:0] want;
    logic [2:0] prevSel;
    logic [2:0] stepSeq [5];
    bit found;
    int dig;

    // Reset state
    applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0);
    repeat (2) @(negedge clk);
    checkOutput("rst_an", an, 8'hFF);
    checkOutput("rst_seg", seg, 8'hFF);
    checkOutput("rst_cursel", {5'b0, curSel}, 8'h00);
    rst = 1'b0;

    // All-zero total scanned across the digits, dp off
    pushValue(32'h0000_0000, 1'b0);
    checkFrame("zero");

    // Distinct hex digits, including lower-case b and d
    applyStimulus(32'h1234_ABCD, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 3'd0);
    repeat (3) @(negedge clk);
    pushValue(32'h1234_ABCD, 1'b0);
    checkFrame("hex");

    // Counting total freezes at 0x100 when lock rises, dp marks the halt
    total = 32'h0000_00F0;
    lockAtHit = 1'b1;
    countEn = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge clk);
      if (lock) found = 1'b1;
    end
    checkOutput("lock_seen", {7'b0, found}, 8'h01);
    repeat (3) @(negedge clk);
    pushValue(32'h0000_0100, 1'b1);
    checkFrame("freeze");

    // Releasing lock resumes live tracking within two cycles
    countEn = 1'b0;
    lockAtHit = 1'b0;
    total = 32'h5555_5555;
    lock = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("unlock_seg", seg, 8'h92);

    // Invalid select shows dashes but still reports the raw code
    sel = 3'd6;
    repeat (2) @(negedge clk);
    checkOutput("dash_cursel", {5'b0, curSel}, 8'h06);
    checkOutput("dash_seg", seg, 8'hBF);
    for (int k = 0; k < 8; k++) expSeg.push_back(8'hBF);
    checkFrame("dash");

    // Back to a valid select: new counter reaches seg two cycles later
    sel = 3'd3;
    conditionalSuccess = 32'h9876_5432;
    repeat (2) @(negedge clk);
    checkOutput("csel_cursel", {5'b0, curSel}, 8'h03);
    dig = 0;
    for (int k = 0; k < 8; k++) if (an[k] == 1'b0) dig = k;
    want = hexSeg(conditionalSuccess[4*dig +: 4]);
    checkOutput("csel_seg", seg, want);
    pushValue(32'h9876_5432, 1'b0);
    checkFrame("csel");

    // Auto-rotate: align to a frame start so no step lands right after enable
    prevAn = an;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (an == 8'hFE && prevAn != 8'hFE) found = 1'b1;
      else prevAn = an;
    end
    autoRot = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rot_start", {5'b0, curSel}, 8'h00);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (curSel == 3'd1) found = 1'b1;
    end
    checkOutput("rot_first", {7'b0, found}, 8'h01);
    stepSeq[0] = 3'd2; stepSeq[1] = 3'd3; stepSeq[2] = 3'd4; stepSeq[3] = 3'd0; stepSeq[4] = 3'd1;
    prevSel = 3'd1;
    for (int s = 0; s < 5; s++) begin
      repeat (63) @(negedge clk);
      checkOutput("rot_hold", {5'b0, curSel}, {5'b0, prevSel});
      @(negedge clk);
      checkOutput("rot_step", {5'b0, curSel}, {5'b0, stepSeq[s]});
      prevSel = stepSeq[s];
    end
    autoRot = 1'b0;
    sel = 3'd0;

    // Reset while locked mid-frame clears everything and releases the freeze
    total = 32'hAAAA_0001;
    lock = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    total = 32'h0000_0077;
    @(negedge clk);
    checkOutput("rstlk_an", an, 8'hFF);
    checkOutput("rstlk_seg", seg, 8'hFF);
    checkOutput("rstlk_cursel", {5'b0, curSel}, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstlk_an0", an, 8'hFE);
    checkOutput("rstlk_snap0", seg, 8'h40);
    total = 32'h1234_5678;
    pushValue(32'h0000_0077, 1'b1);
    checkFrame("relock");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/perf_stat_display.md
# perf_stat_display

Reader side of the CPU performance-counter block: consumes the five 32-bit statistics counters and the halt `LOCK` flag, and presents one selected counter as 8 hex digits on the board's multiplexed 7-segment display. It sits at the FPGA top level, between the counter block and the board pins. It freezes a coherent snapshot of all counters when `LOCK` rises, and can auto-rotate through the counters.

## Interface
Parameters:
- `SCAN_DIV`, 50000 — clocks per digit scan slot (≥2).
- `ROT_FRAMES`, 1000 — full 8-digit frames per auto-rotate step (≥1).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `lock`  in  1  halt lock from counter block; 1 = program halted.
- `total`  in  32  total cycle count.
- `conditional`  in  32  conditional branch count.
- `unconditional`  in  32  unconditional jump count.
- `conditional_success`  in  32  taken/correct conditional branch count.
- `lu_times`  in  32  load-use stall count.
- `sel`  in  3  manual counter select: 0 total, 1 conditional, 2 unconditional, 3 conditional_success, 4 lu_times, 5–7 invalid.
- `auto_rot`  in  1  1 = ignore `sel`, rotate 0→4→0.
- `an`  out  8  digit enables, active-low, one-hot-low; bit 0 = least significant digit.
- `seg`  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- `cur_sel`  out  3  counter index currently displayed.

## Operation
- Snapshot: five 32-bit registers. While `lock`=0, every cycle they load the live inputs. On the cycle `lock` is first seen 1 (rising edge vs registered `lock_q`), they load once and then hold while `lock`=1. When `lock` returns to 0, live tracking resumes.
- Selection: with `auto_rot`=0, `cur_sel` = `sel` registered. With `auto_rot`=1, the rotate index advances at each frame-counter wrap (`ROT_FRAMES` frames) and wraps from 4 to 0. The index holds its value when `auto_rot` drops, and restarts from 0 when `auto_rot` rises.
- Display value: the snapshot selected by `cur_sel`. Digit k shows nibble [4k+3:4k] in hex (0–9, A–F; b and d lower-case).
- Invalid `sel` (5–7): every digit shows "-" (segment g only, seg = 8'hBF). `cur_sel` still reports the raw value.
- Decimal point: lit on digit 0 only while `lock`=1 (halt indicator). Otherwise off.
- Scan: `div_cnt` counts 0..`SCAN_DIV`-1. At wrap, `digit_idx` (3-bit) increments and wraps 7→0. A `digit_idx` wrap increments `frame_cnt` (0..`ROT_FRAMES`-1).

## Timing
- Reset values: `an`=8'hFF, `seg`=8'hFF, `cur_sel`=0. The snapshot, `div_cnt`, `digit_idx`, `frame_cnt`, rotate index and `lock_q` all reset to 0.
- `an`/`seg` are registered. The first cycle after reset release drives `an`=8'hFE with digit 0 of the `total` snapshot (0 → seg 8'hC0).
- Latency from input to pins:
  - Live counter change → snapshot: 1 cycle.
  - Snapshot → `seg`: 1 cycle, so an input change reaches `seg` in 2 cycles while the digit is active.
  - `sel` change → `cur_sel`: 1 cycle, and → `seg`: 2 cycles.
- A `lock` rise in the same cycle as a counter change captures the value present on that cycle.
- `rst` asserted mid-scan or mid-lock forces all reset values on the next edge and clears the freeze.

## Structure
- Shared package `perf_stat_pkg`:
  - select codes `SEL_TOTAL`..`SEL_LU` (3-bit);
  - `SEG_BLANK`=8'hFF and `SEG_DASH`=8'hBF;
  - the `DIGITS`=8 constant.
- Sub-module `seg7_hex_decode`: purely combinational, 4-bit nibble → 7 active-low segments. It is instantiated once on the muxed nibble.
- Remainder is one module: snapshot regs, selection/rotate logic, scan counters, output regs.

## Test plan
Bench parameters: `SCAN_DIV`=4, `ROT_FRAMES`=2.
- Reset, then `total`=32'h0000_0000 → `an` sequence FE,FD,FB,…,7F, each held 4 cycles; `seg`=C0 throughout; dp off.
- `sel`=0, `total`=32'h1234_ABCD → digits 0..7 show D,C,B,A,4,3,2,1, i.e. seg A1,C6,83,88,99,B0,A4,F9.
- `total` incrementing every cycle, `lock` rises when `total`=32'h0000_0100 → displayed value freezes at 0100 while inputs keep counting; digit 0 seg has dp low (seg[7]=0). Dropping `lock` resumes live values within 2 cycles.
- `sel`=6 → all digits seg=BF, `cur_sel`=6; back to `sel`=3 → digits show `conditional_success` 2 cycles later.
- `auto_rot`=1 → `cur_sel` steps 0,1,2,3,4,0 every 64 cycles (2 frames × 8 digits × 4 clocks).
- `rst` pulsed while `lock`=1 mid-frame → next edge: `an`=FF, `seg`=FF, `cur_sel`=0, snapshot 0. The freeze is released and the next captured value follows the live inputs.
